// File: rtl/alu_share_arb_pkg.sv
// Shared types for the ALU-sharing arbiter: functional-unit payload, op codes and
// the registered result record.
package alu_share_arb_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;
    // Wide enough for the largest supported requester count (8)
    localparam int unsigned ARB_IDX_W     = 3;

    typedef logic [XLEN-1:0] xlen_t;

    // ADD is encoding zero so an all-zero payload is a quiet ADD
    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        XORL = 4'd2,
        ORL  = 4'd3,
        ANDL = 4'd4,
        EQ   = 4'd5,
        NE   = 4'd6,
        LTS  = 4'd7,
        LTU  = 4'd8
    } fu_op;

    typedef struct packed {
        fu_op                     operation;
        xlen_t                    operand_a;
        xlen_t                    operand_b;
        xlen_t                    imm;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    typedef struct packed {
        xlen_t                    result;
        logic                     branch;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [ARB_IDX_W-1:0]     req_idx;
    } alu_arb_res_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester, ALU and result-stage signals of the ALU-sharing arbiter.
interface alu_share_arb_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
);
    import alu_share_arb_pkg::*;

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    fu_data_t                 req_data_i [NUM_REQ];
    fu_data_t                 alu_data_o;
    xlen_t                    alu_result_i;
    logic                     alu_branch_res_i;
    logic                     res_valid_o;
    logic                     res_ready_i;
    xlen_t                    res_result_o;
    logic                     res_branch_o;
    logic [TRANS_ID_BITS-1:0] res_trans_id_o;
    logic [IDX_W-1:0]         res_req_idx_o;

    modport slave (
        input  req_valid_i, req_data_i, alu_result_i, alu_branch_res_i, res_ready_i,
        output req_ready_o, alu_data_o, res_valid_o, res_result_o, res_branch_o,
               res_trans_id_o, res_req_idx_o
    );

    modport master (
        output req_valid_i, req_data_i, alu_result_i, alu_branch_res_i, res_ready_i,
        input  req_ready_o, alu_data_o, res_valid_o, res_result_o, res_branch_o,
               res_trans_id_o, res_req_idx_o
    );

endinterface

// File: rtl/alu_share_arb_rr_pick.sv
// Pointer-rotated priority picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest request wins last
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        cand  = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = IDX_W'((32'(ptr_i) + 32'(NUM_REQ - 1 - 32'(k))) % NUM_REQ);
            if (req_i[cand]) begin
                gnt_c       = '0;
                gnt_c[cand] = 1'b1;
                idx_c       = cand;
                any_c       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin share of one combinational ALU between NUM_REQ issue requesters,
// with a single registered valid/ready result stage.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    alu_share_arb_if.slave  bus
);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               res_valid_q, res_valid_d;
    alu_arb_res_t       res_q, res_d;

    logic [NUM_REQ-1:0] gnt_c;
    logic [IDX_W-1:0]   idx_c;
    logic               any_c;
    logic               can_issue_c;
    logic               grant_c;
    fu_data_t           alu_data_c;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i (bus.req_valid_i),
        .ptr_i (ptr_q),
        .gnt_c (gnt_c),
        .idx_c (idx_c),
        .any_c (any_c)
    );

    // Grant depends only on valids, ptr, flush and the result stage, never on payload
    assign can_issue_c     = !rst_i && !flush_i && (!res_valid_q || bus.res_ready_i);
    assign grant_c         = can_issue_c && any_c;
    assign bus.req_ready_o = grant_c ? gnt_c : '0;

    // Idle ALU sees a constant zero ADD
    always_comb begin
        alu_data_c           = '0;
        alu_data_c.operation = ADD;
        if (grant_c) begin
            alu_data_c = bus.req_data_i[idx_c];
        end
    end

    assign bus.alu_data_o = alu_data_c;

    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_d       = res_q;
        if (flush_i) begin
            res_valid_d = 1'b0;
        end else if (grant_c) begin
            res_valid_d    = 1'b1;
            res_d.result   = bus.alu_result_i;
            res_d.branch   = bus.alu_branch_res_i;
            res_d.trans_id = bus.req_data_i[idx_c].trans_id;
            res_d.req_idx  = ARB_IDX_W'(idx_c);
            if (idx_c == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_c + IDX_W'(1);
            end
        end else if (res_valid_q && bus.res_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
        end
    end

    assign bus.res_valid_o    = res_valid_q;
    assign bus.res_result_o   = res_q.result;
    assign bus.res_branch_o   = res_q.branch;
    assign bus.res_trans_id_o = res_q.trans_id;
    assign bus.res_req_idx_o  = IDX_W'(res_q.req_idx);

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb wrapped with a small ALU model; grants are checked at issue,
// results by a scoreboard monitor on the output handshake.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    alu_share_arb_if #(.NUM_REQ(2)) bus ();

    alu_share_arb #(.NUM_REQ(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the execute-stage ALU
    always_comb begin
        bus.alu_result_i     = '0;
        bus.alu_branch_res_i = 1'b0;
        case (bus.alu_data_o.operation)
            ADD:     bus.alu_result_i = bus.alu_data_o.operand_a + bus.alu_data_o.operand_b;
            SUB:     bus.alu_result_i = bus.alu_data_o.operand_a - bus.alu_data_o.operand_b;
            XORL:    bus.alu_result_i = bus.alu_data_o.operand_a ^ bus.alu_data_o.imm;
            EQ:      bus.alu_branch_res_i = (bus.alu_data_o.operand_a == bus.alu_data_o.operand_b);
            NE:      bus.alu_branch_res_i = (bus.alu_data_o.operand_a != bus.alu_data_o.operand_b);
            default: bus.alu_result_i = '0;
        endcase
    end

    xlen_t                    exp_res [2];
    logic                     exp_br  [2];
    logic [TRANS_ID_BITS-1:0] exp_tid [2];
    alu_arb_res_t             q [$];

    task automatic set_req(input int i, input fu_op op, input xlen_t a, input xlen_t b,
                           input logic [TRANS_ID_BITS-1:0] tid, input xlen_t res, input logic br);
        fu_data_t d;
        d               = '0;
        d.operation     = op;
        d.operand_a     = a;
        d.operand_b     = b;
        d.trans_id      = tid;
        bus.req_data_i[i] = d;
        exp_res[i]      = res;
        exp_br[i]       = br;
        exp_tid[i]      = tid;
    endtask

    function automatic alu_arb_res_t mk(input int i);
        alu_arb_res_t r;
        r          = '0;
        r.result   = exp_res[i];
        r.branch   = exp_br[i];
        r.trans_id = exp_tid[i];
        r.req_idx  = ARB_IDX_W'(i);
        return r;
    endfunction

    // One cycle: apply inputs just after the edge, check the grant, queue its result
    task automatic step(input logic [1:0] v, input logic rdy, input logic fl, input logic rs,
                        input logic [1:0] exp_gnt, input string name);
        bus.req_valid_i = v;
        bus.res_ready_i = rdy;
        flush           = fl;
        rst             = rs;
        #2;
        total++;
        if (bus.req_ready_o !== exp_gnt) begin
            bad++;
            $display("FAIL %s grant: got %b want %b", name, bus.req_ready_o, exp_gnt);
        end
        if (exp_gnt[0])      q.push_back(mk(0));
        else if (exp_gnt[1]) q.push_back(mk(1));
        @(posedge clk);
        #2;
        if (fl || rs) begin
            q.delete();
            total++;
            if (bus.res_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL %s discard: res_valid got %b want 0", name, bus.res_valid_o);
            end
        end
    endtask

    // Result monitor: every cycle a result is shown it must match the queue head
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.res_valid_o === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got result=%0d tid=%0d idx=%0d want none",
                         bus.res_result_o, bus.res_trans_id_o, bus.res_req_idx_o);
            end else begin
                if (bus.res_result_o !== q[0].result || bus.res_branch_o !== q[0].branch ||
                    bus.res_trans_id_o !== q[0].trans_id || bus.res_req_idx_o !== q[0].req_idx[0]) begin
                    bad++;
                    $display("FAIL result: got res=%0d br=%b tid=%0d idx=%0d want res=%0d br=%b tid=%0d idx=%0d",
                             bus.res_result_o, bus.res_branch_o, bus.res_trans_id_o, bus.res_req_idx_o,
                             q[0].result, q[0].branch, q[0].trans_id, q[0].req_idx);
                end
                if (bus.res_ready_i) void'(q.pop_front());
            end
        end
    end

    task automatic check_rst(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.req_valid_i = '0;
        bus.res_ready_i = 1'b0;
        set_req(0, ADD, 64'd5, 64'd7, 3'd3, 64'd12, 1'b0);
        set_req(1, SUB, 64'd50, 64'd8, 3'd2, 64'd42, 1'b0);
        @(posedge clk);
        #2;
        // Reset: no grant while held, everything cleared
        step(2'b11, 1'b1, 1'b0, 1'b1, 2'b00, "reset0");
        step(2'b11, 1'b1, 1'b0, 1'b1, 2'b00, "reset1");
        check_rst("rst_result", 64'(bus.res_result_o), 64'd0);
        check_rst("rst_branch", 64'(bus.res_branch_o), 64'd0);
        check_rst("rst_tid",    64'(bus.res_trans_id_o), 64'd0);
        check_rst("rst_idx",    64'(bus.res_req_idx_o), 64'd0);

        // Single request: ADD 5+7, tid 3
        step(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, "single");
        step(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, "single_idle");

        // Both valid, ptr=1: grants alternate 1,0,1,0
        set_req(0, ADD, 64'd10, 64'd20, 3'd1, 64'd30, 1'b0);
        step(2'b11, 1'b1, 1'b0, 1'b0, 2'b10, "rr0");
        step(2'b11, 1'b1, 1'b0, 1'b0, 2'b01, "rr1");
        step(2'b11, 1'b1, 1'b0, 1'b0, 2'b10, "rr2");
        step(2'b11, 1'b1, 1'b0, 1'b0, 2'b01, "rr3");

        // Backpressure: capture req1, stall 3 cycles, then replace with req0
        step(2'b11, 1'b1, 1'b0, 1'b0, 2'b10, "bp_cap");
        step(2'b11, 1'b0, 1'b0, 1'b0, 2'b00, "bp_stall0");
        step(2'b11, 1'b0, 1'b0, 1'b0, 2'b00, "bp_stall1");
        step(2'b11, 1'b0, 1'b0, 1'b0, 2'b00, "bp_stall2");
        step(2'b11, 1'b1, 1'b0, 1'b0, 2'b01, "bp_release");
        step(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, "bp_drain");

        // Branch: EQ 9,9 -> 1; NE 9,9 -> 0
        set_req(0, EQ, 64'd9, 64'd9, 3'd4, 64'd0, 1'b1);
        step(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, "br_eq");
        set_req(0, NE, 64'd9, 64'd9, 3'd5, 64'd0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, "br_ne");
        step(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, "br_drain");

        // Flush with pending result: no grant, result dropped, ptr kept at 0
        set_req(1, ADD, 64'd1, 64'd2, 3'd6, 64'd3, 1'b0);
        step(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, "fl_setup");
        step(2'b11, 1'b0, 1'b1, 1'b0, 2'b00, "flush");
        step(2'b11, 1'b1, 1'b0, 1'b0, 2'b01, "fl_after");
        step(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, "fl_drain");

        // Reset during backpressure with ptr=1: first grant afterwards is index 0
        step(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, "rb_cap");
        step(2'b11, 1'b0, 1'b0, 1'b0, 2'b00, "rb_stall");
        step(2'b11, 1'b0, 1'b0, 1'b1, 2'b00, "rb_reset");
        step(2'b11, 1'b1, 1'b0, 1'b0, 2'b01, "rb_after");
        step(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, "rb_drain");
        step(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, "idle");

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d queued results want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
